// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer: walks IF/RR/EX/MA/RW with req/ack memory handshakes,
// owns the PC and retired-instruction counter, and emits per-stage control strobes.
module stage_sequencer #(
    parameter int unsigned PC_W         = 32,
    parameter logic [31:0] RESET_PC     = 32'h7FFC,
    parameter bit          SKIP_IDLE_MA = 1'b1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [PC_W-1:0]  npc,
    input  logic             is_load,
    input  logic             is_store,
    input  logic             is_halt,
    input  logic             reg_we_req,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic [PC_W-1:0]  pc,
    output logic [2:0]       stage,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             dec_clear,
    output logic             alu_clear,
    output logic             reg_we,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_RR   = 3'd1,
        ST_EX   = 3'd2,
        ST_MA   = 3'd3,
        ST_RW   = 3'd4,
        ST_HALT = 3'd5
    } stage_t;

    localparam logic [PC_W-1:0] LP_RESET_PC = PC_W'(RESET_PC);

    stage_t           r_state;
    stage_t           w_next;
    logic [PC_W-1:0]  r_pc;
    logic [CNT_W-1:0] r_retired;
    logic             r_dec_clear;
    logic             r_alu_clear;
    logic             r_reg_we;
    logic             w_mem_op;
    logic             w_imem_req;
    logic             w_dmem_req;
    logic             w_dmem_we;

    always_comb begin
        w_mem_op   = is_load | is_store;
        w_imem_req = (r_state == ST_IF) & run;
        w_dmem_req = (r_state == ST_MA) & w_mem_op;
        // A simultaneous load+store is resolved as a store.
        w_dmem_we  = w_dmem_req & is_store;
        w_next     = r_state;
        case (r_state)
            ST_IF: begin
                if (w_imem_req && imem_ack) w_next = ST_RR;
            end
            ST_RR: w_next = ST_EX;
            ST_EX: begin
                if (is_halt)                         w_next = ST_HALT;
                else if (w_mem_op || !SKIP_IDLE_MA)  w_next = ST_MA;
                else                                 w_next = ST_RW;
            end
            ST_MA: begin
                if (!w_dmem_req || dmem_ack) w_next = ST_RW;
            end
            ST_RW:   w_next = ST_IF;
            ST_HALT: w_next = ST_HALT;
            default: w_next = ST_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IF;
            r_pc        <= LP_RESET_PC;
            r_retired   <= '0;
            r_dec_clear <= 1'b0;
            r_alu_clear <= 1'b0;
            r_reg_we    <= 1'b0;
        end else begin
            r_state     <= w_next;
            // Strobes are registered so they line up exactly with the stage they belong to.
            r_dec_clear <= (w_next == ST_RR);
            r_alu_clear <= (w_next == ST_EX);
            r_reg_we    <= (w_next == ST_RW) && reg_we_req;
            if (r_state == ST_RW) begin
                r_pc      <= {npc[PC_W-1:2], 2'b00};
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign pc        = r_pc;
    assign stage     = r_state;
    assign imem_req  = w_imem_req;
    assign dmem_req  = w_dmem_req;
    assign dmem_we   = w_dmem_we;
    assign dec_clear = r_dec_clear;
    assign alu_clear = r_alu_clear;
    assign reg_we    = r_reg_we;
    assign halted    = (r_state == ST_HALT);
    assign retired   = r_retired;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: two instances (MA skipping on and off) driven from per-cycle
// tables built by an instruction-level model; each cycle the outputs are compared to the table.
module tb_stage_sequencer;

    typedef struct {
        bit          rst_n, run, imem_ack, dmem_ack, ld, st, hlt, rwe;
        logic [31:0] npc;
        int          stage;
        logic [31:0] pc, ret;
        bit          lit_en;
        logic [31:0] lit_pc, lit_ret;
    } ent_t;

    ent_t        q0[$];
    ent_t        q1[$];
    logic [31:0] m_pc [2];
    logic [31:0] m_ret [2];
    bit          pend_lit [2];
    logic [31:0] pend_pc [2];
    logic [31:0] pend_ret [2];
    int          checks;
    int          failures;
    int          cyc;

    logic        clk;
    logic        rst_n [2];
    logic        run [2];
    logic [31:0] npc [2];
    logic        is_load [2];
    logic        is_store [2];
    logic        is_halt [2];
    logic        reg_we_req [2];
    logic        imem_ack [2];
    logic        dmem_ack [2];
    logic [31:0] pc [2];
    logic [2:0]  stage [2];
    logic        imem_req [2];
    logic        dmem_req [2];
    logic        dmem_we [2];
    logic        dec_clear [2];
    logic        alu_clear [2];
    logic        reg_we [2];
    logic        halted [2];
    logic [31:0] retired [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    stage_sequencer #(.PC_W(32), .RESET_PC(32'h7FFC), .SKIP_IDLE_MA(1'b1), .CNT_W(32)) u_dut_skip (
        .clk(clk), .rst(rst_n[0]), .run(run[0]), .npc(npc[0]),
        .is_load(is_load[0]), .is_store(is_store[0]), .is_halt(is_halt[0]),
        .reg_we_req(reg_we_req[0]), .imem_ack(imem_ack[0]), .dmem_ack(dmem_ack[0]),
        .pc(pc[0]), .stage(stage[0]), .imem_req(imem_req[0]), .dmem_req(dmem_req[0]),
        .dmem_we(dmem_we[0]), .dec_clear(dec_clear[0]), .alu_clear(alu_clear[0]),
        .reg_we(reg_we[0]), .halted(halted[0]), .retired(retired[0])
    );

    stage_sequencer #(.PC_W(32), .RESET_PC(32'h7FFC), .SKIP_IDLE_MA(1'b0), .CNT_W(32)) u_dut_noskip (
        .clk(clk), .rst(rst_n[1]), .run(run[1]), .npc(npc[1]),
        .is_load(is_load[1]), .is_store(is_store[1]), .is_halt(is_halt[1]),
        .reg_we_req(reg_we_req[1]), .imem_ack(imem_ack[1]), .dmem_ack(dmem_ack[1]),
        .pc(pc[1]), .stage(stage[1]), .imem_req(imem_req[1]), .dmem_req(dmem_req[1]),
        .dmem_we(dmem_we[1]), .dec_clear(dec_clear[1]), .alu_clear(alu_clear[1]),
        .reg_we(reg_we[1]), .halted(halted[1]), .retired(retired[1])
    );

    function automatic bit rb();
        return 1'($urandom);
    endfunction

    function automatic ent_t mk(input int inst, input int stg, input bit r, input bit ia,
                                input bit da, input bit ld, input bit st, input bit hlt,
                                input bit rwe, input logic [31:0] nv);
        ent_t e;
        e.rst_n = 1'b1; e.run = r; e.imem_ack = ia; e.dmem_ack = da;
        e.ld = ld; e.st = st; e.hlt = hlt; e.rwe = rwe; e.npc = nv;
        e.stage = stg; e.pc = m_pc[inst]; e.ret = m_ret[inst];
        e.lit_en = 1'b0; e.lit_pc = '0; e.lit_ret = '0;
        return e;
    endfunction

    task automatic push(input int inst, input ent_t e_in);
        ent_t e;
        e = e_in;
        if (pend_lit[inst]) begin
            e.lit_en = 1'b1; e.lit_pc = pend_pc[inst]; e.lit_ret = pend_ret[inst];
            pend_lit[inst] = 1'b0;
        end
        if (inst == 0) q0.push_back(e);
        else           q1.push_back(e);
    endtask

    task automatic pin(input int inst, input logic [31:0] p, input logic [31:0] r);
        pend_lit[inst] = 1'b1; pend_pc[inst] = p; pend_ret[inst] = r;
    endtask

    task automatic add_reset(input int inst, input int n);
        ent_t e;
        m_pc[inst]  = 32'h7FFC;
        m_ret[inst] = 0;
        for (int k = 0; k < n; k++) begin
            e = mk(inst, 0, rb(), rb(), rb(), rb(), rb(), rb(), rb(), $urandom);
            e.rst_n = 1'b0;
            push(inst, e);
        end
    endtask

    // One instruction: IF (run low, then waiting on ack), RR, EX, optional MA, RW or HALT.
    task automatic add_instr(input int inst, input bit skip, input int run_low, input int iwait,
                             input bit ld, input bit st, input bit hlt, input bit rwe,
                             input int dwait, input logic [31:0] nv, input int halt_cyc,
                             input int abort_ma);
        bit mem;
        mem = ld | st;
        for (int k = 0; k < run_low; k++) push(inst, mk(inst, 0, 0, rb(), rb(), ld, st, hlt, rwe, nv));
        for (int k = 0; k < iwait; k++)   push(inst, mk(inst, 0, 1, 0, rb(), ld, st, hlt, rwe, nv));
        push(inst, mk(inst, 0, 1, 1, rb(), ld, st, hlt, rwe, nv));
        push(inst, mk(inst, 1, rb(), rb(), rb(), ld, st, hlt, rwe, nv));
        push(inst, mk(inst, 2, rb(), rb(), rb(), ld, st, hlt, rwe, nv));
        if (hlt) begin
            for (int k = 0; k < halt_cyc; k++) push(inst, mk(inst, 5, rb(), rb(), rb(), ld, st, hlt, rwe, nv));
            return;
        end
        if (mem) begin
            for (int k = 0; k < dwait; k++) begin
                if (k == abort_ma) begin
                    add_reset(inst, 1);
                    return;
                end
                push(inst, mk(inst, 3, rb(), rb(), 0, ld, st, hlt, rwe, nv));
            end
            push(inst, mk(inst, 3, rb(), rb(), 1, ld, st, hlt, rwe, nv));
        end else if (!skip) begin
            push(inst, mk(inst, 3, rb(), rb(), rb(), ld, st, hlt, rwe, nv));
        end
        push(inst, mk(inst, 4, rb(), rb(), rb(), ld, st, hlt, rwe, nv));
        m_pc[inst]  = {nv[31:2], 2'b00};
        m_ret[inst] = m_ret[inst] + 1;
    endtask

    task automatic script(input int inst, input bit skip);
        int          kind;
        bit          ld, st;
        logic [31:0] nv;
        add_reset(inst, 2);
        pin(inst, 32'h7FFC, 0);
        add_instr(inst, skip, 0, 0, 0, 0, 0, 1, 0, m_pc[inst] + 4, 0, -1);
        pin(inst, 32'h8000, 1);
        add_instr(inst, skip, 0, 0, 0, 0, 0, 1, 0, m_pc[inst] + 4, 0, -1);
        pin(inst, 32'h8004, 2);
        add_instr(inst, skip, 0, 0, 0, 0, 0, 0, 0, m_pc[inst] + 4, 0, -1);
        pin(inst, 32'h8008, 3);
        add_instr(inst, skip, 0, 0, 1, 0, 1, 1, 0, m_pc[inst] + 4, 20, -1);
        add_reset(inst, 1);
        pin(inst, 32'h7FFC, 0);
        add_instr(inst, skip, 0, 0, 0, 0, 0, 1, 0, m_pc[inst] + 4, 0, -1);
        pin(inst, 32'h8000, 1);
        add_instr(inst, skip, 0, 0, 0, 1, 0, 0, 3, m_pc[inst] + 4, 0, -1);
        pin(inst, 32'h8004, 2);
        add_instr(inst, skip, 5, 2, 0, 0, 0, 1, 0, 32'h8013, 0, -1);
        pin(inst, 32'h8010, 3);
        add_instr(inst, skip, 0, 0, 1, 0, 0, 1, 6, 32'h8014, 0, 2);
        pin(inst, 32'h7FFC, 0);
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 11));
            ld = rb(); st = rb();
            nv = rb() ? m_pc[inst] + 4 : $urandom;
            if (kind == 0) begin
                add_instr(inst, skip, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                          ld, st, 1, rb(), 0, nv, int'($urandom_range(1, 4)), -1);
                add_reset(inst, 1);
            end else if (kind == 1) begin
                add_reset(inst, 1);
            end else begin
                add_instr(inst, skip, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                          ld, st, 0, rb(), int'($urandom_range(0, 3)), nv, 0,
                          (kind == 2) ? int'($urandom_range(0, 3)) : -1);
            end
        end
    endtask

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d cycle=%0d got=%h expected=%h", nm, inst, cyc, act, exp);
        end
    endtask

    task automatic check_inst(input int inst, input ent_t e);
        bit exp_dreq;
        exp_dreq = (e.stage == 3) && (e.ld || e.st);
        chk("stage",     inst, 32'(stage[inst]),     32'(e.stage));
        chk("pc",        inst, pc[inst],             e.pc);
        chk("retired",   inst, retired[inst],        e.ret);
        chk("imem_req",  inst, 32'(imem_req[inst]),  32'((e.stage == 0) && e.run));
        chk("dmem_req",  inst, 32'(dmem_req[inst]),  32'(exp_dreq));
        chk("dmem_we",   inst, 32'(dmem_we[inst]),   32'(exp_dreq && e.st));
        chk("dec_clear", inst, 32'(dec_clear[inst]), 32'(e.stage == 1));
        chk("alu_clear", inst, 32'(alu_clear[inst]), 32'(e.stage == 2));
        chk("reg_we",    inst, 32'(reg_we[inst]),    32'((e.stage == 4) && e.rwe));
        chk("halted",    inst, 32'(halted[inst]),    32'(e.stage == 5));
        if (e.lit_en) begin
            chk("pinned_pc",  inst, pc[inst],      e.lit_pc);
            chk("pinned_ret", inst, retired[inst], e.lit_ret);
        end
    endtask

    initial begin
        ent_t cur [2];
        int   n;
        checks = 0; failures = 0; cyc = 0;
        for (int i = 0; i < 2; i++) begin
            rst_n[i] = 1'b0; run[i] = 1'b0; npc[i] = '0; is_load[i] = 1'b0; is_store[i] = 1'b0;
            is_halt[i] = 1'b0; reg_we_req[i] = 1'b0; imem_ack[i] = 1'b0; dmem_ack[i] = 1'b0;
            pend_lit[i] = 1'b0;
        end
        script(0, 1'b1);
        script(1, 1'b0);
        while (q0.size() < q1.size()) add_reset(0, 1);
        while (q1.size() < q0.size()) add_reset(1, 1);
        n = q0.size();
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            cyc = c;
            cur[0] = q0.pop_front();
            cur[1] = q1.pop_front();
            for (int i = 0; i < 2; i++) begin
                rst_n[i] = cur[i].rst_n; run[i] = cur[i].run; npc[i] = cur[i].npc;
                is_load[i] = cur[i].ld; is_store[i] = cur[i].st; is_halt[i] = cur[i].hlt;
                reg_we_req[i] = cur[i].rwe; imem_ack[i] = cur[i].imem_ack; dmem_ack[i] = cur[i].dmem_ack;
            end
            @(negedge clk);
            check_inst(0, cur[0]);
            check_inst(1, cur[1]);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
